// File: rtl/multi_spi_shifter.sv
// Framed full-duplex SPI shift engine: MSB-first over 1, 2 or 4 lanes,
// capturing the same number of input bits per en beat.
module multi_spi_shifter #(
    parameter int unsigned REGSIZE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [REGSIZE-1:0] tx_data,
    input  logic               en,
    input  logic               abort,
    input  logic [3:0]         din,
    output logic [3:0]         dout,
    output logic [3:0]         dout_oe,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [REGSIZE-1:0] rx_data
);

    localparam int unsigned CW = $clog2(REGSIZE + 1);
    localparam logic [CW-1:0] BEATS1 = CW'(REGSIZE);
    localparam logic [CW-1:0] BEATS2 = CW'(REGSIZE / 2);
    localparam logic [CW-1:0] BEATS4 = CW'(REGSIZE / 4);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        LANE1 = 2'b00,
        LANE2 = 2'b01,
        LANE4 = 2'b11
    } lane_e;

    state_e             state_q, state_d;
    lane_e              mode_q, mode_d;
    logic [REGSIZE-1:0] sr_q, sr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [REGSIZE-1:0] rx_q, rx_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [REGSIZE-1:0] shifted;

    // Shift form (not part-selects) keeps REGSIZE=4 legal in 4-lane mode.
    always_comb begin
        shifted = sr_q;
        case (mode_q)
            LANE1:   shifted = (sr_q << 1) | REGSIZE'(din[0]);
            LANE2:   shifted = (sr_q << 2) | REGSIZE'(din[1:0]);
            LANE4:   shifted = (sr_q << 4) | REGSIZE'(din);
            default: shifted = sr_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (mode == 2'b10) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        mode_d  = lane_e'(mode);
                        sr_d    = tx_data;
                        case (mode)
                            2'b00:   cnt_d = BEATS1;
                            2'b01:   cnt_d = BEATS2;
                            default: cnt_d = BEATS4;
                        endcase
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (en) begin
                    sr_d  = shifted;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rx_d    = shifted;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= LANE1;
            sr_q    <= '0;
            cnt_q   <= '0;
            rx_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        dout    = '0;
        dout_oe = '0;
        case (mode_q)
            LANE1:   dout = {3'b000, sr_q[REGSIZE-1]};
            LANE2:   dout = {2'b00, sr_q[REGSIZE-1 -: 2]};
            LANE4:   dout = sr_q[REGSIZE-1 -: 4];
            default: dout = '0;
        endcase
        if (state_q == SHIFT) begin
            case (mode_q)
                LANE1:   dout_oe = 4'b0001;
                LANE2:   dout_oe = 4'b0011;
                LANE4:   dout_oe = 4'b1111;
                default: dout_oe = 4'b0000;
            endcase
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign err     = err_q;
    assign rx_data = rx_q;

endmodule

// File: tb/tb_multi_spi_shifter.sv
// Self-checking bench for multi_spi_shifter: directed scenarios plus
// randomized back-to-back frames against a word-level reference model.
module tb_multi_spi_shifter;

    localparam int R = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   mode;
    logic [R-1:0] tx_data;
    logic         en;
    logic         abort;
    logic [3:0]   din;
    logic [3:0]   dout;
    logic [3:0]   dout_oe;
    logic         busy;
    logic         done;
    logic         err;
    logic [R-1:0] rx_data;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [R-1:0] exp_rx = '0;

    always #5 clk = ~clk;

    multi_spi_shifter #(.REGSIZE(R)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .tx_data(tx_data),
        .en(en), .abort(abort), .din(din), .dout(dout), .dout_oe(dout_oe),
        .busy(busy), .done(done), .err(err), .rx_data(rx_data)
    );

    function automatic int lanes(input logic [1:0] m);
        return (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] lane_mask(input int l);
        return 4'((1 << l) - 1);
    endfunction

    // Beat k transmits tx bits [R-1-l*k -: l].
    function automatic logic [3:0] exp_dout(input logic [R-1:0] tx, input int l, input int k);
        logic [R-1:0] t;
        t = tx >> (R - l * (k + 1));
        return 4'(t) & lane_mask(l);
    endfunction

    // Chunk k received lands at bit position l*(beats-1-k).
    function automatic logic [R-1:0] place_chunk(input logic [3:0] d, input int l, input int k);
        return R'(d & lane_mask(l)) << (l * (R / l - 1 - k));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 2'b00; tx_data = '0;
        en = 1'b0; abort = 1'b0; din = '0;
        tick();
        tick();
        tests_run++;
        if ({busy, done, err, dout, dout_oe, rx_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_vals: busy=%b done=%b err=%b dout=%h oe=%h rx=%h required all 0",
                     busy, done, err, dout, dout_oe, rx_data);
        end
        rst = 1'b0;
        tick();
        en = 1'b1; abort = 1'b1; din = 4'hF;
        repeat (3) begin
            tick();
            tests_run++;
            if ({busy, done, err, dout, dout_oe, rx_data} !== '0) begin
                tests_failed++;
                $display("FAIL idle_en_abort: busy=%b done=%b err=%b dout=%h oe=%h rx=%h required all 0",
                         busy, done, err, dout, dout_oe, rx_data);
            end
        end
        en = 1'b0; abort = 1'b0; din = '0;
        tick();
    endtask

    task automatic test_loopback_1lane();
        start = 1'b1; mode = 2'b00; tx_data = 8'hA5;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (busy !== 1'b1 || dout_oe !== 4'b0001 || dout !== exp_dout(8'hA5, 1, k)) begin
                tests_failed++;
                $display("FAIL lb_beat%0d: busy=%b oe=%b dout=%h required busy=1 oe=0001 dout=%h",
                         k, busy, dout_oe, dout, exp_dout(8'hA5, 1, k));
            end
            din = {3'b000, dout[0]};
            en = 1'b1;
            tick();
            en = 1'b0;
            if (k < 7) begin
                tests_run++;
                if (done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL lb_early_done%0d: done=%b required 0", k, done);
                end
            end
        end
        exp_rx = 8'hA5;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || rx_data !== exp_rx || dout_oe !== 4'b0000) begin
            tests_failed++;
            $display("FAIL lb_end: done=%b busy=%b rx=%h oe=%b required done=1 busy=0 rx=%h oe=0000",
                     done, busy, rx_data, dout_oe, exp_rx);
        end
        tick();
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL lb_done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_4lane();
        start = 1'b1; mode = 2'b11; tx_data = 8'h3C;
        tick();
        start = 1'b0;
        tests_run++;
        if (dout !== 4'h3 || dout_oe !== 4'b1111) begin
            tests_failed++;
            $display("FAIL q_beat0: dout=%h oe=%b required dout=3 oe=1111", dout, dout_oe);
        end
        din = 4'h9; en = 1'b1;
        tick();
        tests_run++;
        if (dout !== 4'hC || busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL q_beat1: dout=%h busy=%b done=%b required dout=c busy=1 done=0", dout, busy, done);
        end
        din = 4'h6;
        tick();
        en = 1'b0;
        exp_rx = 8'h96;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || rx_data !== exp_rx) begin
            tests_failed++;
            $display("FAIL q_end: done=%b busy=%b rx=%h required done=1 busy=0 rx=%h", done, busy, rx_data, exp_rx);
        end
        tick();
    endtask

    task automatic test_2lane_gapped();
        logic [1:0]   pairs [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
        logic [R-1:0] tx = R'($urandom);
        start = 1'b1; mode = 2'b01; tx_data = tx;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (dout !== exp_dout(tx, 2, k) || dout_oe !== 4'b0011) begin
                tests_failed++;
                $display("FAIL d_beat%0d: dout=%h oe=%b required dout=%h oe=0011", k, dout, dout_oe, exp_dout(tx, 2, k));
            end
            din = {2'b00, pairs[k]}; en = 1'b1;
            tick();
            en = 1'b0;
            if (k < 3) begin
                for (int g = 0; g < 2; g++) begin
                    din = 4'($urandom);
                    tick();
                    tests_run++;
                    if (busy !== 1'b1 || done !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL d_gap%0d: busy=%b done=%b required busy=1 done=0", k, busy, done);
                    end
                end
            end
        end
        exp_rx = 8'hC9;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || rx_data !== exp_rx) begin
            tests_failed++;
            $display("FAIL d_end: done=%b busy=%b rx=%h required done=1 busy=0 rx=%h", done, busy, rx_data, exp_rx);
        end
        tick();
    endtask

    task automatic test_illegal_and_busy_start();
        logic [R-1:0] tx = R'($urandom);
        logic [R-1:0] rx_m = '0;
        logic [3:0]   d;
        start = 1'b1; mode = 2'b10; tx_data = R'($urandom);
        tick();
        start = 1'b0;
        tests_run++;
        if (err !== 1'b1 || busy !== 1'b0 || dout_oe !== 4'b0000 || rx_data !== exp_rx) begin
            tests_failed++;
            $display("FAIL ill_err: err=%b busy=%b oe=%b rx=%h required err=1 busy=0 oe=0000 rx=%h",
                     err, busy, dout_oe, rx_data, exp_rx);
        end
        tick();
        tests_run++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ill_pulse: err=%b busy=%b required err=0 busy=0", err, busy);
        end
        start = 1'b1; mode = 2'b01; tx_data = tx;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (dout !== exp_dout(tx, 2, k) || err !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL bs_beat%0d: dout=%h err=%b busy=%b required dout=%h err=0 busy=1",
                         k, dout, err, busy, exp_dout(tx, 2, k));
            end
            d = 4'($urandom);
            rx_m = rx_m | place_chunk(d, 2, k);
            din = d; en = 1'b1;
            if (k == 1 || k == 3) begin
                start = 1'b1; mode = 2'b11; tx_data = ~tx;
            end
            tick();
            en = 1'b0; start = 1'b0;
        end
        exp_rx = rx_m;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || rx_data !== exp_rx) begin
            tests_failed++;
            $display("FAIL bs_end: done=%b busy=%b err=%b rx=%h required done=1 busy=0 err=0 rx=%h",
                     done, busy, err, rx_data, exp_rx);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL bs_final_start: busy=%b done=%b required busy=0 done=0", busy, done);
        end
    endtask

    task automatic test_abort();
        logic [R-1:0] tx = R'($urandom);
        logic [R-1:0] rx_m = '0;
        logic [3:0]   d;
        start = 1'b1; mode = 2'b00; tx_data = tx;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (dout !== exp_dout(tx, 1, k)) begin
                tests_failed++;
                $display("FAIL ab_beat%0d: dout=%h required %h", k, dout, exp_dout(tx, 1, k));
            end
            din = 4'($urandom); en = 1'b1;
            tick();
            en = 1'b0;
        end
        din = 4'($urandom); en = 1'b1; abort = 1'b1;
        tick();
        en = 1'b0; abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || rx_data !== exp_rx || dout_oe !== 4'b0000) begin
            tests_failed++;
            $display("FAIL ab_cancel: busy=%b done=%b rx=%h oe=%b required busy=0 done=0 rx=%h oe=0000",
                     busy, done, rx_data, dout_oe, exp_rx);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || rx_data !== exp_rx) begin
            tests_failed++;
            $display("FAIL ab_no_done: done=%b rx=%h required done=0 rx=%h", done, rx_data, exp_rx);
        end
        tx = R'($urandom);
        start = 1'b1; abort = 1'b1; mode = 2'b11; tx_data = tx;
        tick();
        start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (busy !== 1'b1 || dout !== exp_dout(tx, 4, k)) begin
                tests_failed++;
                $display("FAIL ab_restart%0d: busy=%b dout=%h required busy=1 dout=%h", k, busy, dout, exp_dout(tx, 4, k));
            end
            d = 4'($urandom);
            rx_m = rx_m | place_chunk(d, 4, k);
            din = d; en = 1'b1;
            tick();
            en = 1'b0;
        end
        exp_rx = rx_m;
        tests_run++;
        if (done !== 1'b1 || rx_data !== exp_rx) begin
            tests_failed++;
            $display("FAIL ab_restart_end: done=%b rx=%h required done=1 rx=%h", done, rx_data, exp_rx);
        end
        tick();
    endtask

    // Each new frame starts in the cycle done is high, giving back-to-back frames.
    task automatic test_back_to_back();
        logic [1:0]   modes [3] = '{2'b00, 2'b01, 2'b11};
        logic [1:0]   m;
        logic [R-1:0] tx;
        logic [R-1:0] rx_m;
        logic [3:0]   d;
        int           l;
        for (int f = 0; f < 24; f++) begin
            m = modes[$urandom_range(0, 2)];
            l = lanes(m);
            tx = R'($urandom);
            rx_m = '0;
            start = 1'b1; mode = m; tx_data = tx;
            tick();
            start = 1'b0;
            tests_run++;
            if (busy !== 1'b1 || dout_oe !== lane_mask(l)) begin
                tests_failed++;
                $display("FAIL bb_start%0d: busy=%b oe=%b required busy=1 oe=%b", f, busy, dout_oe, lane_mask(l));
            end
            for (int k = 0; k < R / l; k++) begin
                tests_run++;
                if (dout !== exp_dout(tx, l, k)) begin
                    tests_failed++;
                    $display("FAIL bb_dout%0d_%0d: dout=%h required %h", f, k, dout, exp_dout(tx, l, k));
                end
                d = 4'($urandom);
                rx_m = rx_m | place_chunk(d, l, k);
                din = d; en = 1'b1;
                tick();
                en = 1'b0;
                if (k < R / l - 1) begin
                    repeat ($urandom_range(0, 2)) begin
                        din = 4'($urandom);
                        tick();
                        tests_run++;
                        if (busy !== 1'b1 || done !== 1'b0) begin
                            tests_failed++;
                            $display("FAIL bb_gap%0d: busy=%b done=%b required busy=1 done=0", f, busy, done);
                        end
                    end
                end
            end
            exp_rx = rx_m;
            tests_run++;
            if (done !== 1'b1 || busy !== 1'b0 || rx_data !== exp_rx) begin
                tests_failed++;
                $display("FAIL bb_end%0d: done=%b busy=%b rx=%h required done=1 busy=0 rx=%h",
                         f, done, busy, rx_data, exp_rx);
            end
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || rx_data !== exp_rx) begin
            tests_failed++;
            $display("FAIL bb_idle: done=%b busy=%b rx=%h required done=0 busy=0 rx=%h", done, busy, rx_data, exp_rx);
        end
    endtask

    task automatic test_reset_midframe();
        start = 1'b1; mode = 2'b00; tx_data = R'($urandom) | 8'h80;
        tick();
        start = 1'b0;
        repeat (3) begin
            din = 4'($urandom); en = 1'b1;
            tick();
        end
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, err, dout, dout_oe, rx_data} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid: busy=%b done=%b err=%b dout=%h oe=%h rx=%h required all 0",
                     busy, done, err, dout, dout_oe, rx_data);
        end
        tick();
        rst = 1'b0;
        exp_rx = '0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || rx_data !== exp_rx) begin
            tests_failed++;
            $display("FAIL rst_release: busy=%b done=%b rx=%h required busy=0 done=0 rx=0", busy, done, rx_data);
        end
    endtask

    initial begin
        test_reset();
        test_loopback_1lane();
        test_4lane();
        test_2lane_gapped();
        test_illegal_and_busy_start();
        test_abort();
        test_back_to_back();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/multi_spi_shifter.md
# multi_spi_shifter

Parametrised multi-lane SPI shift engine. It generalises the single, dual and quad input shift register to a framed, full-duplex engine. The engine loads a transmit word, shifts it out MSB-first on 1, 2 or 4 data lanes while capturing the same number of input bits per beat, counts beats, and delivers a completed receive word with a done pulse. It sits between the SPI pin interface (which supplies the shift strobe) and the register or FIFO logic that consumes received words.

## Interface
- REGSIZE, 8, frame width in bits; must be a multiple of 4 and at least 4.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a frame; sampled only when idle.
- mode  in  2  lane select sampled with start: 00 = 1 lane, 01 = 2 lanes, 11 = 4 lanes, 10 = illegal.
- tx_data  in  REGSIZE  word to transmit, sampled with start.
- en  in  1  shift strobe (one beat); ignored when idle.
- abort  in  1  synchronous frame cancel.
- din  in  4  serial input lanes; lane 0 is used in 1-lane mode, lanes 1:0 in 2-lane mode, lanes 3:0 in 4-lane mode.
- dout  out  4  serial output lanes; MSB-first slice of the shift register.
- dout_oe  out  4  lane output enables.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame completes.
- err  out  1  one-cycle pulse on illegal mode at start.
- rx_data  out  REGSIZE  last completed received word; held until the next completion.

## Operation
- States: IDLE and SHIFT, held as one busy flag plus a latched lane mode.
- In IDLE with start=1 and mode legal:
  - shift register <= tx_data
  - latched mode <= mode
  - beat counter <= REGSIZE/L, where L = 1, 2 or 4
  - go to SHIFT
- In IDLE with start=1 and mode=10: err pulses for one cycle and the block stays in IDLE. Nothing else changes.
- start while busy is ignored, with no error.
- In SHIFT with en=1, the shift register takes {sr[REGSIZE-1-L:0], din[L-1:0]} and the counter decrements.
  - When the counter goes from 1 to 0: rx_data <= the shifted value, done=1 on the next cycle, return to IDLE.
- dout is combinational from the shift register:
  - 1 lane: dout[0] = sr[REGSIZE-1].
  - 2 lanes: dout[1:0] = sr[REGSIZE-1:REGSIZE-2].
  - 4 lanes: dout[3:0] = sr[REGSIZE-1:REGSIZE-4].
  - Unused lanes drive 0.
- dout_oe is 0001, 0011 or 1111 per latched mode while busy, and 0000 when idle.
- abort=1 in SHIFT returns the block to IDLE on the next edge. There is no done pulse and rx_data is unchanged.
- abort has priority over en in the same cycle. abort in IDLE has no effect and does not block start.
- Beat counter width is $clog2(REGSIZE+1). It never underflows because en is ignored in IDLE.

## Timing
- Reset values (asynchronous, immediate): busy=0, done=0, err=0, rx_data=0, shift register=0, counter=0, dout=0, dout_oe=0.
- start accepted on edge N: busy=1 and dout shows tx_data MSBs from edge N.
- A frame takes exactly REGSIZE/L en beats. en may be held continuously (one beat per cycle) or gapped arbitrarily.
- done and busy=0 are visible the cycle after the final beat edge. rx_data is valid in the same cycle as done.
- start in the same cycle as the final beat is ignored (block still busy). The earliest restart is the cycle done is high, which makes frames back-to-back with one idle cycle between them.
- err is visible the cycle after the illegal start.
- Reset asserted mid-frame drops busy immediately. There is no done pulse, and rx_data is cleared to 0.

## Test plan
- Reset and idle:
  - Stimulus: assert rst mid-frame, then release.
  - Required: all outputs 0; en and abort while idle cause no change.
- 1-lane loopback (REGSIZE=8):
  - Stimulus: start with tx_data=0xA5, mode=00; din[0]=dout[0] for 8 beats.
  - Required: done after 8th beat, rx_data=0xA5, dout_oe=0001 while busy.
- 4-lane frame:
  - Stimulus: tx_data=0x3C, mode=11; din nibbles 0x9 then 0x6 on consecutive cycles.
  - Required: dout shows 0x3 then 0xC; done after 2 beats; rx_data=0x96.
- 2-lane with gapped en:
  - Stimulus: mode=01, din pairs 11,00,10,01 with idle cycles between strobes.
  - Required: rx_data=0xC9 after exactly 4 strobes; busy stays 1 throughout the gaps.
- Illegal mode and start-while-busy:
  - Stimulus: start with mode=10.
  - Required: err pulse, busy stays 0.
  - Stimulus: start during SHIFT.
  - Required: ignored; frame completes with the original tx_data.
- Abort:
  - Stimulus: abort after 3 of 8 beats, with en=1 in the same cycle.
  - Required: busy=0 next cycle, no done, rx_data unchanged; a subsequent start is accepted normally.
